// File: rtl/e_arb.sv
// ---------------------------------------------------------------------------
// e      : unary-admission checker (combinational).
//          Admits a W-bit vector that is a unary code: ones packed at the low
//          end with zeros above (2^n - 1, n < W). With P_ADMIT_COMPLIMENT_EN=1
//          the bitwise complement of such a code is admitted instead.
//          o_len is the index of the single 0/1 transition (0 when there is
//          none, and forced to 0 when the vector is rejected).
//   i_x        in  W          candidate vector
//   o_is_unary out 1          admission decision
//   o_len      out $clog2(W)  transition index
//
// e_arb  : shares one e instance between N requesters. A round-robin grant
//          picks one valid request per cycle; the checked result is
//          registered with the requester id behind a valid/ready port.
//          Saturating accept/reject counters track every decision.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req_vld[N]      request valid per requester
//   i_req_x[N*W]      request vector k at [k*W +: W]
//   o_req_rdy[N]      one-hot accept strobe (combinational from i_req_vld)
//   o_rsp_vld/i_rsp_rdy  response handshake
//   o_rsp_id/o_rsp_is_unary/o_rsp_len  response payload
//   o_acc_cnt/o_rej_cnt  saturating admitted/rejected counts
// ---------------------------------------------------------------------------

module e #(
    parameter int W                     = 16,
    parameter int P_ADMIT_COMPLIMENT_EN = 0
) (
    input  logic [W-1:0]         i_x,
    output logic                 o_is_unary,
    output logic [$clog2(W)-1:0] o_len
);
    localparam int LW = $clog2(W);

    // edges_v[i-1] marks a transition between bit i-1 and bit i.
    logic [W-2:0]  edges_v;
    logic          at_most_one;
    logic          polarity_ok;
    logic [LW-1:0] len_raw;

    generate
        for (genvar gi = 1; gi < W; gi++) begin : g_edge
            assign edges_v[gi-1] = i_x[gi] ^ i_x[gi-1];
        end
    endgenerate

    // A unary code has at most one transition, and its MSB tells which way
    // round it is: 0 for plain codes, 1 for complemented ones.
    assign at_most_one = (edges_v & (edges_v - (W-1)'(1))) == '0;
    assign polarity_ok = (i_x[W-1] == 1'(P_ADMIT_COMPLIMENT_EN));
    assign o_is_unary  = at_most_one & polarity_ok;

    always_comb begin
        len_raw = '0;
        for (int i = 1; i < W; i++) begin
            if (edges_v[i-1]) begin
                len_raw = LW'(i);
            end
        end
    end

    assign o_len = o_is_unary ? len_raw : '0;

endmodule

module e_arb #(
    parameter int W                     = 16,
    parameter int N                     = 4,
    parameter int P_ADMIT_COMPLIMENT_EN = 0,
    parameter int CNT_W                 = 16,
    localparam int IDW                  = (N > 1) ? $clog2(N) : 1,
    localparam int LW                   = $clog2(W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N-1:0]     i_req_vld,
    input  logic [N*W-1:0]   i_req_x,
    output logic [N-1:0]     o_req_rdy,
    output logic             o_rsp_vld,
    input  logic             i_rsp_rdy,
    output logic [IDW-1:0]   o_rsp_id,
    output logic             o_rsp_is_unary,
    output logic [LW-1:0]    o_rsp_len,
    output logic [CNT_W-1:0] o_acc_cnt,
    output logic [CNT_W-1:0] o_rej_cnt
);
    // Registered state
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             rsp_is_unary_q, rsp_is_unary_d;
    logic [LW-1:0]    rsp_len_q, rsp_len_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0] rej_cnt_q, rej_cnt_d;

    // Grant and datapath
    logic             adv;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_id;
    logic             xfer;
    logic [W-1:0]     req_x_arr [N];
    logic [W-1:0]     sel_x;
    logic             chk_is_unary;
    logic [LW-1:0]    chk_len;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            assign req_x_arr[gi] = i_req_x[gi*W +: W];
            assign o_req_rdy[gi] = xfer & (gnt_id == IDW'(gi));
        end
    endgenerate

    // The output slot can take a new response when empty or being drained.
    assign adv = ~rsp_vld_q | i_rsp_rdy;

    // Round-robin search starting at ptr_q, wrapping modulo N.
    always_comb begin
        int cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int j = 0; j < N; j++) begin
            cand = int'(ptr_q) + j;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_found && i_req_vld[IDW'(cand)]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(cand);
            end
        end
    end

    // Nothing is accepted while reset is held, so no request is lost.
    assign xfer  = adv & gnt_found & ~i_rst;
    assign sel_x = req_x_arr[gnt_id];

    e #(
        .W                     (W),
        .P_ADMIT_COMPLIMENT_EN (P_ADMIT_COMPLIMENT_EN)
    ) u_e (
        .i_x        (sel_x),
        .o_is_unary (chk_is_unary),
        .o_len      (chk_len)
    );

    always_comb begin
        ptr_d          = ptr_q;
        rsp_vld_d      = rsp_vld_q;
        rsp_id_d       = rsp_id_q;
        rsp_is_unary_d = rsp_is_unary_q;
        rsp_len_d      = rsp_len_q;
        acc_cnt_d      = acc_cnt_q;
        rej_cnt_d      = rej_cnt_q;
        if (xfer) begin
            // A new response overwrites a draining one in the same edge.
            rsp_vld_d      = 1'b1;
            rsp_id_d       = gnt_id;
            rsp_is_unary_d = chk_is_unary;
            rsp_len_d      = chk_len;
            if (int'(gnt_id) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_id + IDW'(1);
            end
            if (chk_is_unary) begin
                if (acc_cnt_q != '1) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                end
            end else begin
                if (rej_cnt_q != '1) begin
                    rej_cnt_d = rej_cnt_q + CNT_W'(1);
                end
            end
        end else if (i_rsp_rdy) begin
            rsp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q          <= '0;
            rsp_vld_q      <= 1'b0;
            rsp_id_q       <= '0;
            rsp_is_unary_q <= 1'b0;
            rsp_len_q      <= '0;
            acc_cnt_q      <= '0;
            rej_cnt_q      <= '0;
        end else begin
            ptr_q          <= ptr_d;
            rsp_vld_q      <= rsp_vld_d;
            rsp_id_q       <= rsp_id_d;
            rsp_is_unary_q <= rsp_is_unary_d;
            rsp_len_q      <= rsp_len_d;
            acc_cnt_q      <= acc_cnt_d;
            rej_cnt_q      <= rej_cnt_d;
        end
    end

    assign o_rsp_vld      = rsp_vld_q;
    assign o_rsp_id       = rsp_id_q;
    assign o_rsp_is_unary = rsp_is_unary_q;
    assign o_rsp_len      = rsp_len_q;
    assign o_acc_cnt      = acc_cnt_q;
    assign o_rej_cnt      = rej_cnt_q;

endmodule

// File: tb/tb_e_arb.sv
// ---------------------------------------------------------------------------
// Bench for e_arb. Three instances share clock, reset and response-ready:
//   dut0: N=4, P=0, CNT_W=16
//   dut1: N=3, P=1, CNT_W=16
//   dut2: N=4, P=0, CNT_W=2
// Each instance has its own requesters. A reference model predicts grants,
// responses and counters from the rules: unary means the vector (or its
// complement when P=1) equals 2^n-1 for some n < 16, and len is that n.
// ---------------------------------------------------------------------------

module tb_e_arb;

    localparam int ND   [3] = '{4, 3, 4};
    localparam int PD   [3] = '{0, 1, 0};
    localparam int CMAX [3] = '{65535, 65535, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   rsp_rdy;
    logic [2:0][3:0]        vld_s;
    logic [2:0][3:0][15:0]  x_s;

    logic [3:0]  rdy0, rdy2;
    logic [2:0]  rdy1;
    logic        vld0, vld1, vld2;
    logic [1:0]  id0, id1, id2;
    logic        un0, un1, un2;
    logic [3:0]  len0, len1, len2;
    logic [15:0] acc0, rej0, acc1, rej1;
    logic [1:0]  acc2, rej2;

    logic [3:0]  d_rdy [3];
    logic        d_vld [3];
    logic [1:0]  d_id  [3];
    logic        d_un  [3];
    logic [3:0]  d_len [3];
    logic [15:0] d_acc [3];
    logic [15:0] d_rej [3];

    assign d_rdy[0] = rdy0;  assign d_rdy[1] = {1'b0, rdy1};  assign d_rdy[2] = rdy2;
    assign d_vld[0] = vld0;  assign d_vld[1] = vld1;          assign d_vld[2] = vld2;
    assign d_id[0]  = id0;   assign d_id[1]  = id1;           assign d_id[2]  = id2;
    assign d_un[0]  = un0;   assign d_un[1]  = un1;           assign d_un[2]  = un2;
    assign d_len[0] = len0;  assign d_len[1] = len1;          assign d_len[2] = len2;
    assign d_acc[0] = acc0;  assign d_acc[1] = acc1;          assign d_acc[2] = {14'b0, acc2};
    assign d_rej[0] = rej0;  assign d_rej[1] = rej1;          assign d_rej[2] = {14'b0, rej2};

    e_arb #(.W(16), .N(4), .P_ADMIT_COMPLIMENT_EN(0), .CNT_W(16)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_req_vld(vld_s[0]), .i_req_x(x_s[0]),
        .o_req_rdy(rdy0), .o_rsp_vld(vld0), .i_rsp_rdy(rsp_rdy), .o_rsp_id(id0),
        .o_rsp_is_unary(un0), .o_rsp_len(len0), .o_acc_cnt(acc0), .o_rej_cnt(rej0));

    e_arb #(.W(16), .N(3), .P_ADMIT_COMPLIMENT_EN(1), .CNT_W(16)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_req_vld(vld_s[1][2:0]), .i_req_x(x_s[1][2:0]),
        .o_req_rdy(rdy1), .o_rsp_vld(vld1), .i_rsp_rdy(rsp_rdy), .o_rsp_id(id1),
        .o_rsp_is_unary(un1), .o_rsp_len(len1), .o_acc_cnt(acc1), .o_rej_cnt(rej1));

    e_arb #(.W(16), .N(4), .P_ADMIT_COMPLIMENT_EN(0), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_req_vld(vld_s[2]), .i_req_x(x_s[2]),
        .o_req_rdy(rdy2), .o_rsp_vld(vld2), .i_rsp_rdy(rsp_rdy), .o_rsp_id(id2),
        .o_rsp_is_unary(un2), .o_rsp_len(len2), .o_acc_cnt(acc2), .o_rej_cnt(rej2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d got 0x%0h want 0x%0h at %0t", name, d, got, want, $time);
        end
    endtask

    // Reference: x is admitted when (P ? ~x : x) == 2^n - 1 for some n in 0..15.
    function automatic bit ref_unary(input logic [15:0] x, input int p);
        logic [15:0] v;
        v = (p != 0) ? ~x : x;
        for (int n = 0; n < 16; n++) begin
            if ({16'b0, v} == ((32'd1 << n) - 32'd1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int ref_len(input logic [15:0] x, input int p);
        logic [15:0] v;
        v = (p != 0) ? ~x : x;
        for (int n = 0; n < 16; n++) begin
            if ({16'b0, v} == ((32'd1 << n) - 32'd1)) return n;
        end
        return 0;
    endfunction

    // Model state per instance.
    int       m_ptr [3];
    bit       m_vld [3];
    bit       m_known [3];
    int       m_id  [3];
    bit       m_un  [3];
    int       m_len [3];
    int       m_acc [3];
    int       m_rej [3];
    logic [3:0] xfer [3];

    // Compare process: at each falling edge, check the DUT against the model,
    // then advance the model by what the next rising edge must do.
    initial begin
        for (int d = 0; d < 3; d++) begin
            m_ptr[d] = 0; m_vld[d] = 0; m_known[d] = 1; m_id[d] = 0;
            m_un[d] = 0; m_len[d] = 0; m_acc[d] = 0; m_rej[d] = 0; xfer[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                logic [3:0] er;
                int g;
                int k;
                bit adv;
                er  = '0;
                g   = -1;
                adv = !m_vld[d] || rsp_rdy;
                if (!rst) begin
                    for (int j = 0; j < ND[d]; j++) begin
                        k = (m_ptr[d] + j) % ND[d];
                        if (g < 0 && vld_s[d][k]) g = k;
                    end
                end
                if (!rst && adv && g >= 0) er[g] = 1'b1;

                chk("req_rdy", d, {28'b0, d_rdy[d]}, {28'b0, er});
                chk("rsp_vld", d, {31'b0, d_vld[d]}, {31'b0, m_vld[d]});
                chk("acc_cnt", d, {16'b0, d_acc[d]}, m_acc[d]);
                chk("rej_cnt", d, {16'b0, d_rej[d]}, m_rej[d]);
                if (m_vld[d] || m_known[d]) begin
                    chk("rsp_id", d, {30'b0, d_id[d]}, m_id[d]);
                    chk("rsp_unary", d, {31'b0, d_un[d]}, {31'b0, m_un[d]});
                    chk("rsp_len", d, {28'b0, d_len[d]}, m_len[d]);
                end

                if (rst) begin
                    m_ptr[d] = 0; m_vld[d] = 0; m_known[d] = 1; m_id[d] = 0;
                    m_un[d] = 0; m_len[d] = 0; m_acc[d] = 0; m_rej[d] = 0;
                end else if (er != '0) begin
                    m_vld[d]   = 1;
                    m_known[d] = 1;
                    m_id[d]    = g;
                    m_un[d]    = ref_unary(x_s[d][g], PD[d]);
                    m_len[d]   = m_un[d] ? ref_len(x_s[d][g], PD[d]) : 0;
                    m_ptr[d]   = (g + 1) % ND[d];
                    if (m_un[d]) begin
                        if (m_acc[d] < CMAX[d]) m_acc[d] = m_acc[d] + 1;
                    end else begin
                        if (m_rej[d] < CMAX[d]) m_rej[d] = m_rej[d] + 1;
                    end
                end else if (rsp_rdy && m_vld[d]) begin
                    m_vld[d]   = 0;
                    m_known[d] = 0;
                end
                xfer[d] = er;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request on requester 0 of every instance.
    task automatic set_all(input logic [15:0] v);
        for (int d = 0; d < 3; d++) begin
            vld_s[d]    = 4'b0001;
            x_s[d][0]   = v;
        end
    endtask

    function automatic logic [15:0] gen_x();
        int n;
        logic [31:0] m;
        n = $urandom_range(0, 16);
        m = (32'd1 << n) - 32'd1;
        case ($urandom_range(0, 4))
            0:       return m[15:0];
            1:       return ~m[15:0];
            2:       return 16'($urandom);
            3:       return m[15:0] ^ (16'd1 << $urandom_range(0, 15));
            default: return ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    initial begin
        rst = 1'b1; rsp_rdy = 1'b0; vld_s = '0; x_s = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_vld", 0, {31'b0, vld0}, 0);
        chk("rst_id",  0, {30'b0, id0},  0);
        chk("rst_len", 0, {28'b0, len0}, 0);
        chk("rst_acc", 0, {16'b0, acc0}, 0);
        rst = 1'b0;

        // Single unary request: 0x0007 -> len 3, one cycle latency
        set_all(16'h0007); rsp_rdy = 1'b1;
        tick(); vld_s = '0;
        chk("t1_vld", 0, {31'b0, vld0}, 1);
        chk("t1_id",  0, {30'b0, id0},  0);
        chk("t1_un",  0, {31'b0, un0},  1);
        chk("t1_len", 0, {28'b0, len0}, 3);
        chk("t1_acc", 0, {16'b0, acc0}, 1);
        tick();
        chk("t1_drain", 0, {31'b0, vld0}, 0);

        // All requesters valid every cycle from a fresh pointer
        rst = 1'b1; tick(); rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            vld_s[d] = 4'hF;
            for (int k = 0; k < 4; k++) x_s[d][k] = 16'h00FF;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t2_id",  0, {30'b0, id0},  i % 4);
            chk("t2_vld", 0, {31'b0, vld0}, 1);
        end

        // Stall with requester 1 pending behind response id 3
        rsp_rdy = 1'b0; vld_s = {3{4'b0010}};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_rdy", 0, {28'b0, rdy0}, 0);
            chk("t3_id",  0, {30'b0, id0},  3);
            chk("t3_len", 0, {28'b0, len0}, 8);
        end
        rsp_rdy = 1'b1; #1;
        chk("t3_grant", 0, {28'b0, rdy0}, 32'h2);
        tick(); vld_s = '0;
        chk("t3_newid", 0, {30'b0, id0}, 1);

        // Multi-edge and all-zero vectors
        set_all(16'h0505); tick(); vld_s = '0;
        chk("t4_un",  0, {31'b0, un0},  0);
        chk("t4_len", 0, {28'b0, len0}, 0);
        chk("t4_rej", 0, {16'b0, rej0}, 1);
        chk("t4_acc", 0, {16'b0, acc0}, 9);
        set_all(16'h0000); tick(); vld_s = '0;
        chk("t4_zero_p0", 0, {31'b0, un0}, 1);
        chk("t4_zlen_p0", 0, {28'b0, len0}, 0);
        chk("t4_zero_p1", 1, {31'b0, un1}, 0);

        // Complemented codes
        set_all(16'hFFF8); tick(); vld_s = '0;
        chk("t5_un",  1, {31'b0, un1},  1);
        chk("t5_len", 1, {28'b0, len1}, 3);
        set_all(16'hFFFF); tick(); vld_s = '0;
        chk("t5_ones_p1", 1, {31'b0, un1},  1);
        chk("t5_olen_p1", 1, {28'b0, len1}, 0);
        chk("t5_ones_p0", 0, {31'b0, un0},  0);

        // Counter saturation then reset with a pending response
        set_all(16'h0007);
        repeat (5) tick();
        chk("t6_sat", 2, {30'b0, acc2}, 3);
        rsp_rdy = 1'b0; rst = 1'b1; vld_s = {3{4'hF}}; #1;
        chk("t6_rdy_in_rst", 0, {28'b0, rdy0}, 0);
        tick();
        chk("t6_vld", 0, {31'b0, vld0}, 0);
        chk("t6_acc", 2, {30'b0, acc2}, 0);
        chk("t6_rej", 0, {16'b0, rej0}, 0);
        rst = 1'b0; #1;
        chk("t6_first", 0, {28'b0, rdy0}, 1);
        chk("t6_first", 1, {29'b0, rdy1}, 1);
        tick();
        chk("t6_id", 0, {30'b0, id0}, 0);

        // Random traffic: requesters hold until accepted
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 3; d++) begin
                for (int k = 0; k < 4; k++) begin
                    if (xfer[d][k]) vld_s[d][k] = 1'b0;
                    if (!vld_s[d][k] && ($urandom % 3) == 0) begin
                        vld_s[d][k] = 1'b1;
                        x_s[d][k]   = gen_x();
                    end
                end
            end
            rsp_rdy = ($urandom % 4) != 0;
            rst     = ($urandom % 150) == 0;
            tick();
        end
        rst = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
